mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch stage (read-only) and the memory-access stage (read/write) of the 5-stage pipelined CPU.
- Sequences each access through a request/ready handshake to the memory and returns data with a one-cycle ack pulse.
- Drives stall outputs so the pipeline holds IF and/or MEM while their access is pending.
- Includes a watchdog that aborts hung transactions.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage
// (read-only) and the memory-access stage (read/write) of the pipeline.
// Each access runs IDLE -> BUSY_I/BUSY_D -> DONE, with a watchdog that
// aborts a hung memory handshake and returns all-ones data.
// Optional feature: define ARB_RR_EN for round-robin tie-break between the
// two requesters; the default build uses fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_rdy,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Abort fires on the last allowed busy cycle, so m_req is high for
    // exactly TIMEOUT cycles when the memory never answers.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wdog;
    logic       grant_d;

`ifdef ARB_RR_EN
    // 1 = data was granted last, 0 = fetch was granted last.
    logic       last_grant;

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant_d = d_req & (~i_req | ~last_grant);
    end
`else
    // Fixed priority: the memory-access stage holds the older instruction.
    always_comb begin
        grant_d = d_req;
    end
`endif

    // Stalls follow the request directly so the pipeline holds in the same cycle.
    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

    // Arbiter FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            wdog        <= 8'd0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ARB_RR_EN
            last_grant  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wdog <= 8'd0;
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        busy    <= 1'b1;
`ifdef ARB_RR_EN
                        last_grant <= 1'b1;
`endif
                    end else if (i_req) begin
                        state  <= BUSY_I;
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                        busy   <= 1'b1;
`ifdef ARB_RR_EN
                        last_grant <= 1'b0;
`endif
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (m_rdy) begin
                        // Normal completion: capture data, ack lands in DONE.
                        if (state == BUSY_I) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        state <= DONE;
                    end else if (wdog == WD_LIMIT) begin
                        // Watchdog abort: still ack so the pipeline cannot deadlock.
                        if (state == BUSY_I) begin
                            i_rdata <= '1;
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= '1;
                            d_ack   <= 1'b1;
                        end
                        m_req       <= 1'b0;
                        m_we        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end

                DONE: begin
                    // Requests are not re-sampled here, preventing double service.
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    wdog  <= 8'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven bench for mem_port_arbiter with a small
// memory responder, plus hand-written idle-m_rdy and async-reset sequences.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_rdy;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    // Model of the round-robin pointer: 1 = data granted last.
    logic lg_model = 1'b0;

    typedef struct {
        logic        i_on;
        logic [15:0] i_addr;
        logic        d_on;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        int          dly;      // cycles of m_req before m_rdy; 255 = never
        logic [15:0] mem;
        int          lat1;     // negedge index of first ack
        int          lat2;     // negedge index of second ack (ties only)
        logic [15:0] exp_ird;
        logic [15:0] exp_drd;
        logic        exp_terr;
    } vec_t;

    vec_t vecs [10];
    vec_t post_rst;

    mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_ack       (i_ack),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_rdy       (m_rdy),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one table record from a negedge and check every cycle until idle.
    task automatic run_txn(input vec_t v);
        logic tie;
        logic first_d;
        logic serve_d;
        logic exp_mreq;
        logic exp_busy;
        int   lat_i;
        int   lat_d;
        int   last;
        int   cnt;

        tie = v.i_on && v.d_on;
`ifdef ARB_RR_EN
        first_d = v.d_on && (!v.i_on || !lg_model);
`else
        first_d = v.d_on;
`endif
        lat_i = 0;
        lat_d = 0;
        if (tie) begin
            lat_d = first_d ? v.lat1 : v.lat2;
            lat_i = first_d ? v.lat2 : v.lat1;
            last  = v.lat2;
            lg_model = !first_d;
        end else begin
            if (v.d_on) lat_d = v.lat1;
            if (v.i_on) lat_i = v.lat1;
            last = v.lat1;
            lg_model = v.d_on;
        end

        i_req   = v.i_on;
        i_addr  = v.i_addr;
        d_req   = v.d_on;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        m_rdy   = 1'b0;
        cnt     = 0;

        for (int k = 1; k <= last + 1; k++) begin
            @(negedge Clk);
            serve_d  = first_d;
            exp_mreq = (k >= 1 && k <= v.lat1 - 1);
            if (tie && k >= v.lat1 + 2 && k <= v.lat2 - 1) begin
                exp_mreq = 1'b1;
                serve_d  = !first_d;
            end
            exp_busy = (k <= v.lat1) || (tie && k >= v.lat1 + 2 && k <= v.lat2);

            chk("i_ack", {31'd0, i_ack}, {31'd0, (lat_i == k)});
            chk("d_ack", {31'd0, d_ack}, {31'd0, (lat_d == k)});
            chk("stall_if", {31'd0, stall_if}, {31'd0, (i_req && lat_i != k)});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, (d_req && lat_d != k)});
            chk("m_req", {31'd0, m_req}, {31'd0, exp_mreq});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (exp_mreq) begin
                chk("m_addr", {16'd0, m_addr}, {16'd0, serve_d ? v.d_addr : v.i_addr});
                chk("m_we", {31'd0, m_we}, {31'd0, serve_d && v.d_we});
                if (serve_d && v.d_we) begin
                    chk("m_wdata", {16'd0, m_wdata}, {16'd0, v.d_wdata});
                end
            end
            if (lat_i == k) begin
                chk("i_rdata", {16'd0, i_rdata}, {16'd0, v.exp_ird});
                i_req = 1'b0;
            end
            if (lat_d == k) begin
                chk("d_rdata", {16'd0, d_rdata}, {16'd0, v.exp_drd});
                d_req = 1'b0;
            end

            // Memory responder: answer after v.dly cycles of m_req.
            m_rdata = v.mem;
            if (m_req) begin
                m_rdy = (v.dly != 255) && (cnt == v.dly);
                cnt++;
            end else begin
                m_rdy = 1'b0;
                cnt   = 0;
            end
        end
        m_rdy = 1'b0;
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, v.exp_terr});
    endtask

    initial begin
        //         i_on  i_addr    d_on  we    d_addr    d_wdata   dly  mem       lat1 lat2 exp_ird   exp_drd   terr
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,   16'hA123, 2,   0,   16'hA123, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1,   16'h1234, 3,   0,   16'hA123, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h5A5A, 3,   16'hBEEF, 5,   0,   16'hA123, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0000, 0,   16'hC003, 2,   5,   16'hC003, 16'hC003, 1'b0};
        vecs[4] = '{1'b1, 16'h0101, 1'b1, 1'b0, 16'h0201, 16'h0000, 0,   16'hC004, 2,   5,   16'hC004, 16'hC004, 1'b0};
        vecs[5] = '{1'b1, 16'h0102, 1'b1, 1'b0, 16'h0202, 16'h0000, 0,   16'hC005, 2,   5,   16'hC005, 16'hC005, 1'b0};
        vecs[6] = '{1'b1, 16'h0103, 1'b1, 1'b0, 16'h0203, 16'h0000, 0,   16'hC006, 2,   5,   16'hC006, 16'hC006, 1'b0};
        vecs[7] = '{1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000, 255, 16'h9999, 16,  0,   16'hFFFF, 16'hC006, 1'b1};
        vecs[8] = '{1'b1, 16'h0400, 1'b0, 1'b0, 16'h0000, 16'h0000, 2,   16'h7777, 4,   0,   16'h7777, 16'hC006, 1'b1};
        vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0000, 2,   16'h4321, 4,   0,   16'h7777, 16'h4321, 1'b1};
        post_rst = '{1'b1, 16'h0700, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'h2468, 2,   0,   16'h2468, 16'h0000, 1'b0};

        Rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = 16'h0000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        m_rdata = 16'h0000;
        m_rdy   = 1'b0;

        // Reset state.
        @(negedge Clk);
        @(negedge Clk);
        chk("rst m_req", {31'd0, m_req}, 32'd0);
        chk("rst m_we", {31'd0, m_we}, 32'd0);
        chk("rst i_ack", {31'd0, i_ack}, 32'd0);
        chk("rst d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst m_addr", {16'd0, m_addr}, 32'd0);
        chk("rst m_wdata", {16'd0, m_wdata}, 32'd0);
        chk("rst i_rdata", {16'd0, i_rdata}, 32'd0);
        chk("rst d_rdata", {16'd0, d_rdata}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        for (int n = 0; n < 10; n++) begin
            run_txn(vecs[n]);
        end

        // m_rdy while idle must be ignored.
        m_rdata = 16'h1111;
        m_rdy   = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("idle rdy busy", {31'd0, busy}, 32'd0);
        chk("idle rdy i_ack", {31'd0, i_ack}, 32'd0);
        chk("idle rdy d_ack", {31'd0, d_ack}, 32'd0);
        chk("idle rdy m_req", {31'd0, m_req}, 32'd0);
        chk("idle rdy i_rdata", {16'd0, i_rdata}, 32'h7777);
        m_rdy = 1'b0;
        @(negedge Clk);

        // Asynchronous reset in the middle of a data read.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0600;
        @(negedge Clk);
        chk("pre-rst m_req", {31'd0, m_req}, 32'd1);
        chk("pre-rst busy", {31'd0, busy}, 32'd1);
        #2;
        Rst = 1'b1;
        #1;
        chk("async m_req", {31'd0, m_req}, 32'd0);
        chk("async busy", {31'd0, busy}, 32'd0);
        chk("async i_ack", {31'd0, i_ack}, 32'd0);
        chk("async d_ack", {31'd0, d_ack}, 32'd0);
        chk("async timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("async m_addr", {16'd0, m_addr}, 32'd0);
        d_req = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        lg_model = 1'b0;
        @(negedge Clk);
        chk("post-rst no ack", {31'd0, d_ack}, 32'd0);
        run_txn(post_rst);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Acks must never coincide.
    always @(negedge Clk) begin
        if (i_ack && d_ack) begin
            errors++;
            $display("FAIL dual_ack: got i_ack=%b d_ack=%b required not both", i_ack, d_ack);
        end
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
